// File: rtl/result_accumulator.sv
// Output-stationary row accumulator for a systolic array: sums deskewed partial-sum
// rows into a tile buffer with saturation, then drains the tile row by row with optional ReLU.
module result_accumulator #(
  parameter int MATRIX_SIZE    = 8,
  parameter int PARTIAL_SUM_BW = 20,
  parameter int ACC_BW         = 24,
  parameter int ACC_DEPTH      = 8
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               in_valid,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data,
  input  logic                               tile_first,
  input  logic                               tile_last,
  input  logic                               relu_en,
  output logic                               in_ready,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ACC_BW*MATRIX_SIZE-1:0]      out_data,
  output logic                               sat_flag,
  output logic                               drop_err
);

  localparam int PTR_W = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ACC_DEPTH - 1);

  typedef enum logic {ACCUM = 1'b0, DRAIN = 1'b1} state_t;

  state_t state, state_nxt;

  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic                      first_q;
  logic                      last_q;
  logic signed [ACC_BW-1:0]  buf_mem [ACC_DEPTH][MATRIX_SIZE];

  logic                      accept;
  logic                      eff_first;
  logic                      eff_last;
  logic signed [ACC_BW-1:0]  lane_ext [MATRIX_SIZE];
  logic signed [ACC_BW:0]    lane_sum [MATRIX_SIZE];
  logic signed [ACC_BW-1:0]  upd_row  [MATRIX_SIZE];
  logic [MATRIX_SIZE-1:0]    upd_sat;

  // Clamp a one-bit-wider sum back into the ACC_BW two's-complement range.
  function automatic logic signed [ACC_BW-1:0] saturate(input logic signed [ACC_BW:0] x);
    if (x[ACC_BW] != x[ACC_BW-1])
      return x[ACC_BW] ? {1'b1, {(ACC_BW-1){1'b0}}} : {1'b0, {(ACC_BW-1){1'b1}}};
    else
      return x[ACC_BW-1:0];
  endfunction

  function automatic logic is_ovf(input logic signed [ACC_BW:0] x);
    return x[ACC_BW] != x[ACC_BW-1];
  endfunction

  function automatic logic signed [ACC_BW-1:0] relu(input logic signed [ACC_BW-1:0] x,
                                                    input logic en);
    return (en && x[ACC_BW-1]) ? '0 : x;
  endfunction

  assign accept = in_valid && (state == ACCUM);

  // Tile flags are live on row 0 and come from the registered copy afterwards.
  always_comb begin
    eff_first = (wr_ptr == '0) ? tile_first : first_q;
    eff_last  = (wr_ptr == '0) ? tile_last  : last_q;
  end

  always_comb begin
    upd_sat = '0;
    for (int l = 0; l < MATRIX_SIZE; l++) begin
      lane_ext[l] = {{(ACC_BW-PARTIAL_SUM_BW){in_data[l*PARTIAL_SUM_BW + PARTIAL_SUM_BW-1]}},
                     in_data[l*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]};
      lane_sum[l] = {buf_mem[wr_ptr][l][ACC_BW-1], buf_mem[wr_ptr][l]}
                  + {lane_ext[l][ACC_BW-1], lane_ext[l]};
      if (eff_first) begin
        upd_row[l] = lane_ext[l];
        upd_sat[l] = 1'b0;
      end else begin
        upd_row[l] = saturate(lane_sum[l]);
        upd_sat[l] = is_ovf(lane_sum[l]);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ACCUM;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (accept && (wr_ptr == LAST_PTR) && eff_last) state_nxt = DRAIN;
      DRAIN: if (out_ready && (rd_ptr == LAST_PTR))          state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DRAIN);
    for (int l = 0; l < MATRIX_SIZE; l++)
      out_data[l*ACC_BW +: ACC_BW] = relu(buf_mem[rd_ptr][l], relu_en);
  end

  // Reset clears the buffer too, so an abandoned tile cannot leak into the next one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      sat_flag <= 1'b0;
      drop_err <= 1'b0;
      for (int d = 0; d < ACC_DEPTH; d++)
        for (int l = 0; l < MATRIX_SIZE; l++)
          buf_mem[d][l] <= '0;
    end else begin
      drop_err <= in_valid && (state == DRAIN);
      if (accept) begin
        for (int l = 0; l < MATRIX_SIZE; l++)
          buf_mem[wr_ptr][l] <= upd_row[l];
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
        if (wr_ptr == '0) begin
          first_q <= tile_first;
          last_q  <= tile_last;
        end
        if (|upd_sat) sat_flag <= 1'b1;
      end
      if ((state == DRAIN) && out_ready)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
    end
  end

endmodule

// File: tb/tb_result_accumulator.sv
// Directed bench for result_accumulator: expected rows go into a queue at stimulus time,
// a negedge monitor pops and compares every accepted output row.
module tb_result_accumulator;
  localparam int MS = 8;
  localparam int PW = 20;
  localparam int AW = 24;
  localparam int D  = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0;
  logic tile_first = 1'b0;
  logic tile_last = 1'b0;
  logic relu_en = 1'b0;
  logic out_ready = 1'b0;
  logic [PW*MS-1:0] in_data = '0;
  logic in_ready, out_valid, sat_flag, drop_err;
  logic [AW*MS-1:0] out_data;

  int checks = 0;
  int errors = 0;
  logic [AW*MS-1:0] exp_q[$];
  logic held_v = 1'b0;
  logic [AW*MS-1:0] held_d = '0;
  logic [3:0] pat = 4'b1001;

  always #5 clk = ~clk;

  result_accumulator #(.MATRIX_SIZE(MS), .PARTIAL_SUM_BW(PW), .ACC_BW(AW), .ACC_DEPTH(D)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
    .tile_first(tile_first), .tile_last(tile_last), .relu_en(relu_en),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sat_flag(sat_flag), .drop_err(drop_err)
  );

  task automatic check(input string name, input logic [AW*MS-1:0] act, input logic [AW*MS-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [PW*MS-1:0] mk_in(input int b, input int ls);
    logic [PW*MS-1:0] r;
    int v;
    for (int l = 0; l < MS; l++) begin
      v = b + l * ls;
      r[l*PW +: PW] = v[PW-1:0];
    end
    return r;
  endfunction

  function automatic logic [AW*MS-1:0] mk_exp(input int b, input int ls, input bit relu);
    logic [AW*MS-1:0] r;
    int v;
    for (int l = 0; l < MS; l++) begin
      v = b + l * ls;
      if (relu && v < 0) v = 0;
      r[l*AW +: AW] = v[AW-1:0];
    end
    return r;
  endfunction

  // Row r lane l carries b0 + r*rs + l*ls; noise puts inverted flags on rows 1..7.
  task automatic send_tile(input int b0, input int rs, input int ls,
                           input logic f, input logic lst, input bit noise);
    for (int r = 0; r < D; r++) begin
      in_valid   = 1'b1;
      in_data    = mk_in(b0 + r * rs, ls);
      tile_first = (r == 0) ? f   : (noise ? !f   : 1'b0);
      tile_last  = (r == 0) ? lst : (noise ? !lst : 1'b0);
      @(posedge clk); #1;
    end
    in_valid   = 1'b0;
    tile_first = 1'b0;
    tile_last  = 1'b0;
  endtask

  task automatic push_tile(input int b0, input int rs, input int ls, input bit relu);
    for (int r = 0; r < D; r++) exp_q.push_back(mk_exp(b0 + r * rs, ls, relu));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, {{(AW*MS-1){1'b0}}, (exp_q.size() == 0 && in_ready)}, 1);
  endtask

  // Monitor: accepted rows are popped and compared; stalled rows must not change.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) held_v = 1'b0;
      else if (out_valid) begin
        if (held_v) check("stall_stable", out_data, held_d);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_row actual=%h required=none", out_data);
          end else begin
            check("row", out_data, exp_q.pop_front());
          end
        end
        held_v = !out_ready;
        held_d = out_data;
      end else held_v = 1'b0;
    end
  end

  initial begin
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_drop_err", drop_err, 0);
    #12 rstn = 1'b1;
    @(posedge clk); #1;

    // Single tile, pass-through, first output one cycle after last beat
    out_ready = 1'b1;
    push_tile(0, 8, 1, 0);
    send_tile(0, 8, 1, 1'b1, 1'b1, 0);
    check("drain_latency", out_valid, 1);
    wait_idle("drain_single");

    // Two tiles accumulate 5 + -2; flags on rows 1..7 must be ignored
    push_tile(3, 0, 0, 0);
    send_tile(5, 0, 0, 1'b1, 1'b0, 1);
    check("no_drain_after_a", out_valid, 0);
    check("ready_after_a", in_ready, 1);
    send_tile(-2, 0, 0, 1'b0, 1'b1, 1);
    wait_idle("drain_two_tiles");

    // 5 + -7 with ReLU clamps to 0
    relu_en = 1'b1;
    push_tile(-2, 0, 0, 1);
    send_tile(5, 0, 0, 1'b1, 1'b0, 0);
    send_tile(-7, 0, 0, 1'b0, 1'b1, 0);
    wait_idle("drain_relu");
    relu_en = 1'b0;

    // Backpressure pattern 1,0,0,1 on distinct signed rows
    out_ready = 1'b1;
    push_tile(-30000, 8000, 1000, 0);
    send_tile(-30000, 8000, 1000, 1'b1, 1'b1, 0);
    for (int k = 1; k < 64 && !(exp_q.size() == 0 && in_ready); k++) begin
      out_ready = pat[k % 4];
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle("drain_backpressure");

    // Input beat during a stalled drain is dropped
    out_ready = 1'b0;
    push_tile(9, 0, 1, 0);
    send_tile(9, 0, 1, 1'b1, 1'b1, 0);
    in_valid   = 1'b1;
    in_data    = mk_in(-1000, 0);
    tile_first = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    tile_first = 1'b0;
    check("drop_err_pulse", drop_err, 1);
    @(posedge clk); #1;
    check("drop_err_clear", drop_err, 0);
    out_ready = 1'b1;
    wait_idle("drain_after_drop");

    // 32 tiles of 0x7FFFF saturate to 0x7FFFFF
    check("sat_before", sat_flag, 0);
    push_tile(32'h7FFFFF, 0, 0, 0);
    for (int t = 0; t < 32; t++)
      send_tile(32'h7FFFF, 0, 0, (t == 0), (t == 31), 0);
    check("sat_set", sat_flag, 1);
    wait_idle("drain_sat");
    push_tile(1, 0, 0, 0);
    send_tile(1, 0, 0, 1'b1, 1'b1, 0);
    wait_idle("drain_after_sat");
    check("sat_sticky", sat_flag, 1);

    // Reset after 3 rows; next 8 beats form a fresh tile over cleared entries
    for (int r = 0; r < 3; r++) begin
      in_valid   = 1'b1;
      in_data    = mk_in(77, 0);
      tile_first = (r == 0);
      tile_last  = (r == 0);
      @(posedge clk); #1;
    end
    in_valid   = 1'b0;
    tile_first = 1'b0;
    tile_last  = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sat_flag", sat_flag, 0);
    check("mid_rst_drop_err", drop_err, 0);
    #3 rstn = 1'b1;
    @(posedge clk); #1;
    push_tile(1, 8, 1, 0);
    send_tile(1, 8, 1, 1'b0, 1'b1, 0);
    wait_idle("drain_after_reset");

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
